comple2_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit two's-complement unit (operand A, control cmp, result R) among NREQ requesters.
- Accepts one request at a time over valid/ready.
- Drives the shared unit for one settle cycle and registers its result.
- Returns the result with the requester ID over a valid/ready response channel.
- Sits between the ALU operand sources and the complement datapath, so only one complement unit is needed.

---
 rtl/comple2_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_comple2_rr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comple2_rr_arbiter.sv
// Round-robin front end for one shared 16-bit two's-complement unit: accepts one
// request at a time, drives the unit for a settle cycle, and returns the tagged result.
module comple2_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_cmp,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      cu_a,
  output logic                  cu_cmp,
  input  logic [WIDTH-1:0]      cu_r,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_ovf,
  input  logic                  rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   gid_r;
  logic [WIDTH-1:0] op_r;
  logic             cmp_r;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic [IDW-1:0]   rsp_id_r;
  logic             rsp_ovf_r;

  logic             grant_found_s;
  logic [IDW-1:0]   grant_idx_s;
  logic [NREQ-1:0]  req_ready_s;
  int               cand_s;

  // Negating the most-negative value has no representable result.
  function automatic logic ovf_check(input logic c, input logic [WIDTH-1:0] v);
    return c & (v == {1'b1, {(WIDTH-1){1'b0}}});
  endfunction

  // Rotating priority search starting just after the last served requester.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = (int'(ptr_r) + k) % NREQ;
      if (!grant_found_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = IDW'(cand_s);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Accept strobe is offered only while idle, one-hot at the granted index.
  always_comb begin
    req_ready_s = '0;
    if ((state_r == IDLE) && grant_found_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Sequencer: IDLE accepts, CALC captures the unit result, RESP holds it until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= IDW'(NREQ - 1);
      gid_r       <= '0;
      op_r        <= '0;
      cmp_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_id_r    <= '0;
      rsp_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if ((req_valid & req_ready_s) != '0) begin
            op_r    <= req_data[grant_idx_s*WIDTH +: WIDTH];
            cmp_r   <= req_cmp[grant_idx_s];
            gid_r   <= grant_idx_s;
            state_r <= CALC;
          end
        end
        CALC: begin
          rsp_data_r  <= cu_r;
          rsp_id_r    <= gid_r;
          rsp_ovf_r   <= ovf_check(cmp_r, op_r);
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            ptr_r       <= gid_r;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign cu_a      = op_r;
  assign cu_cmp    = cmp_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_ovf   = rsp_ovf_r;

endmodule

// File: tb/tb_comple2_rr_arbiter.sv
// Directed bench for comple2_rr_arbiter with a behavioural complement unit on cu_*.
module tb_comple2_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_cmp;
  logic [3:0]  req_ready;
  logic [15:0] cu_a;
  logic        cu_cmp;
  logic [15:0] cu_r;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ovf;
  logic        rsp_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign cu_r = cu_cmp ? (~cu_a + 16'd1) : cu_a;

  comple2_rr_arbiter #(.NREQ(4), .WIDTH(16), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_cmp(req_cmp), .req_ready(req_ready),
    .cu_a(cu_a), .cu_cmp(cu_cmp), .cu_r(cu_r),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ovf(rsp_ovf),
    .rsp_ready(rsp_ready)
  );

  // Stimulus only: one request from requester id, response taken as soon as it appears.
  task automatic do_txn(input int id, input logic [15:0] d, input logic c,
                        output logic [15:0] rd, output logic [1:0] rid,
                        output logic rovf, output logic to);
    int n;
    to = 1'b0;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_data[id*16 +: 16] = d;
    req_cmp[id] = c;
    #1;
    n = 0;
    while (req_ready[id] !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
    if (req_ready[id] !== 1'b1) to = 1'b1;
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    if (rsp_valid !== 1'b1) to = 1'b1;
    rd = rsp_data; rid = rsp_id; rovf = rsp_ovf;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'h0; req_data = 64'h0; req_cmp = 4'h0; rsp_ready = 1'b0;
    #12;
    vectors++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_ovf, req_ready, cu_a, cu_cmp} !== 41'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rsp_valid, rsp_data, rsp_id, rsp_ovf, req_ready, cu_a, cu_cmp});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, req_ready} !== 5'd0) begin
      miscompares++; $display("FAIL idle_after_reset: got %h expected 0", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid[0] = 1'b1; req_data[15:0] = 16'h0005; req_cmp[0] = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL single_ready: got %b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    vectors++;
    if ({req_ready, rsp_valid, cu_a, cu_cmp} !== {4'b0000, 1'b0, 16'h0005, 1'b1}) begin
      miscompares++;
      $display("FAIL single_calc: got ready=%b v=%b a=%h c=%b expected 0000 0 0005 1",
               req_ready, rsp_valid, cu_a, cu_cmp);
    end
    @(posedge clk); #1;
    vectors++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_ovf} !== {1'b1, 16'hFFFB, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_rsp: got v=%b d=%h id=%0d ovf=%b expected 1 fffb 0 0",
               rsp_valid, rsp_data, rsp_id, rsp_ovf);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_done: got rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_edges();
    logic [15:0] din [6] = '{16'h1234, 16'h0000, 16'h8000, 16'h8000, 16'hFFFF, 16'h7FFF};
    logic        cin [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] rexp [6] = '{16'h1234, 16'h0000, 16'h8000, 16'h8000, 16'h0001, 16'h8001};
    logic        oexp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] rd;
    logic [1:0]  rid;
    logic        rovf, to;
    for (int i = 0; i < 6; i++) begin
      do_txn(i % 4, din[i], cin[i], rd, rid, rovf, to);
      vectors++;
      if ({to, rd, rid, rovf} !== {1'b0, rexp[i], 2'(i % 4), oexp[i]}) begin
        miscompares++;
        $display("FAIL edge_%0d: got to=%b d=%h id=%0d ovf=%b expected 0 %h %0d %b",
                 i, to, rd, rid, rovf, rexp[i], i % 4, oexp[i]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [15:0] rexp [4] = '{16'h0010, 16'hFFE0, 16'h0030, 16'hFFC0};
    logic [15:0] rd;
    logic [1:0]  rid;
    logic        rovf, to;
    int got, cyc, last;
    do_txn(3, 16'h0003, 1'b0, rd, rid, rovf, to);
    vectors++;
    if ({to, rd, rid} !== {1'b0, 16'h0003, 2'd3}) begin
      miscompares++; $display("FAIL fair_prep: got to=%b d=%h id=%0d expected 0 0003 3", to, rd, rid);
    end
    req_data = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    req_cmp = 4'b1010;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'hF;
    got = 0; cyc = 0; last = 0;
    while (got < 6 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (rsp_valid === 1'b1) begin
        vectors++;
        if ({rsp_id, rsp_data} !== {2'(got % 4), rexp[got % 4]}) begin
          miscompares++;
          $display("FAIL fair_rsp_%0d: got id=%0d d=%h expected %0d %h",
                   got, rsp_id, rsp_data, got % 4, rexp[got % 4]);
        end
        if (got > 0) begin
          vectors++;
          if (cyc - last !== 3) begin
            miscompares++; $display("FAIL fair_spacing_%0d: got %0d expected 3", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
    end
    req_valid = 4'h0;
    vectors++;
    if (got !== 6) begin
      miscompares++; $display("FAIL fair_count: got %0d expected 6", got);
    end
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_data[15:0] = 16'h00AA; req_cmp[0] = 1'b1;
    req_data[31:16] = 16'h0BBB; req_cmp[1] = 1'b0;
    req_valid = 4'b0011;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL bp_first_grant: got %b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_data, rsp_id, req_ready} !== {1'b1, 16'hFF56, 2'd0, 4'b0000}) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got v=%b d=%h id=%0d ready=%b expected 1 ff56 0 0000",
                 i, rsp_valid, rsp_data, rsp_id, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++;
    if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin
      miscompares++; $display("FAIL bp_next_grant: got v=%b ready=%b expected 0 0010", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_ovf} !== {1'b1, 16'h0BBB, 2'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL bp_second_rsp: got v=%b d=%h id=%0d ovf=%b expected 1 0bbb 1 0",
               rsp_valid, rsp_data, rsp_id, rsp_ovf);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_data[47:32] = 16'h1111; req_cmp[2] = 1'b1; req_valid = 4'b0100;
    @(posedge clk); #1;
    req_valid = 4'h0;
    vectors++;
    if (cu_a !== 16'h1111) begin
      miscompares++; $display("FAIL mid_calc_operand: got %h expected 1111", cu_a);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_ovf, req_ready, cu_a, cu_cmp} !== 41'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {rsp_valid, rsp_data, rsp_id, rsp_ovf, req_ready, cu_a, cu_cmp});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL mid_abandoned: got rsp_valid=%b expected 0", rsp_valid);
    end
    req_data[15:0] = 16'h0001; req_cmp[0] = 1'b0;
    req_data[47:32] = 16'h0002; req_cmp[2] = 1'b1;
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 16'h0001}) begin
      miscompares++; $display("FAIL mid_rsp0: got v=%b id=%0d d=%h expected 1 0 0001", rsp_valid, rsp_id, rsp_data);
    end
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++; $display("FAIL mid_second_grant: got %b expected 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 16'hFFFE}) begin
      miscompares++; $display("FAIL mid_rsp2: got v=%b id=%0d d=%h expected 1 2 fffe", rsp_valid, rsp_id, rsp_data);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] rd;
    logic [1:0]  rid;
    logic        rovf, to;
    do_txn(3, 16'h0100, 1'b1, rd, rid, rovf, to);
    vectors++;
    if ({to, rd, rid} !== {1'b0, 16'hFF00, 2'd3}) begin
      miscompares++; $display("FAIL wrap_req3: got to=%b d=%h id=%0d expected 0 ff00 3", to, rd, rid);
    end
    @(negedge clk);
    req_data[31:16] = 16'h4321; req_cmp[1] = 1'b0; req_valid = 4'b1010;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++; $display("FAIL wrap_grant: got %b expected 0010", req_ready);
    end
    req_valid = 4'b0000;
    do_txn(1, 16'h4321, 1'b0, rd, rid, rovf, to);
    vectors++;
    if ({to, rd, rid, rovf} !== {1'b0, 16'h4321, 2'd1, 1'b0}) begin
      miscompares++; $display("FAIL wrap_req1: got to=%b d=%h id=%0d ovf=%b expected 0 4321 1 0", to, rd, rid, rovf);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_edges();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
